// File: rtl/mult_8x8_issue_pkg.sv
// rtl/mult_8x8_issue_pkg.sv - shared phase type and widths for the multiplier issue stage
package mult_pkg;
    typedef enum logic {PH_A = 1'b0, PH_B = 1'b1} mul_phase_e;

    localparam int OPW     = 8;
    localparam int PRODW   = 16;
    // cycles from the issue (phase-A) cycle to the cycle the product is valid on mul_prod
    localparam int MUL_LAT = 2;
endpackage

// File: rtl/mult_8x8_issue_if.sv
// rtl/mult_8x8_issue_if.sv - operand and result handshake bundle of the multiplier issue stage
interface mult_8x8_issue_if;
    import mult_pkg::*;

    logic             s_valid;
    logic             s_ready;
    logic [OPW-1:0]   s_a;
    logic [OPW-1:0]   s_b;
    logic             m_valid;
    logic             m_ready;
    logic [PRODW-1:0] m_prod;

    modport slave (
        input  s_valid, s_a, s_b, m_ready,
        output s_ready, m_valid, m_prod
    );

    modport master (
        output s_valid, s_a, s_b, m_ready,
        input  s_ready, m_valid, m_prod
    );
endinterface

// File: rtl/mult_8x8.sv
// rtl/mult_8x8.sv - two-phase 8x8 multiplier: low nibble of in_2 in IDLE, high nibble in s0
module mult_8x8 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_1,
    input  logic [7:0]  in_2,
    output logic [15:0] prod
);
    typedef enum logic {IDLE = 1'b0, S0 = 1'b1} mul_state_e;

    mul_state_e  r_state;
    mul_state_e  w_state_nxt;
    logic [11:0] r_partial;
    logic [15:0] r_prod;
    logic [11:0] w_lo;
    logic [15:0] w_hi;

    assign w_lo = 12'(in_1) * 12'(in_2[3:0]);
    assign w_hi = (16'(in_1) * 16'(in_2[7:4])) << 4;
    assign prod = r_prod;

    always_comb begin
        w_state_nxt = IDLE;
        if (r_state == IDLE) w_state_nxt = S0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_partial <= '0;
            r_prod    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE) begin
                r_partial <= w_lo;
            end else begin
                r_prod <= 16'(r_partial) + w_hi;
            end
        end
    end
endmodule

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - circular-buffer FIFO, first-word-fall-through from registered storage
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_wdata,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_rdata,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    // a pop frees the head slot in the same cycle, so push-at-full with pop is legal
    assign w_do_push = i_push && (!o_full || i_pop);
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - (AW+1)'(1);
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_push && o_full && !i_pop));
endmodule

// File: rtl/mult_8x8_issue.sv
// rtl/mult_8x8_issue.sv - feeds operand pairs to mult_8x8 over two phases and queues the products
module mult_8x8_issue
    import mult_pkg::*;
#(
    parameter int OUT_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    mult_8x8_issue_if.slave   s_if,
    output logic [OPW-1:0]    mul_in_1,
    output logic [OPW-1:0]    mul_in_2,
    input  logic [PRODW-1:0]  mul_prod
);
    localparam int CW = $clog2(OUT_DEPTH) + 1;
    localparam int RW = $clog2(OUT_DEPTH + MUL_LAT) + 1;

    mul_phase_e          r_phase;
    mul_phase_e          w_phase_nxt;
    logic [OPW-1:0]      r_hold_a;
    logic [OPW-1:0]      r_hold_b;
    logic [MUL_LAT-1:0]  r_inflight;
    logic [CW-1:0]       w_fifo_count;
    logic [RW-1:0]       w_reserved;
    logic                w_s_ready;
    logic                w_accept;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;

    // every op in the multiplier already owns a FIFO slot, so a capture can never overflow
    always_comb begin
        w_reserved = RW'(w_fifo_count);
        for (int i = 0; i < MUL_LAT; i++) begin
            w_reserved = w_reserved + RW'(r_inflight[i]);
        end
    end

    always_comb begin
        w_phase_nxt = PH_A;
        w_s_ready   = 1'b0;
        mul_in_1    = '0;
        mul_in_2    = '0;
        case (r_phase)
            PH_A: begin
                w_phase_nxt = PH_B;
                w_s_ready   = rst_n && (w_reserved < RW'(OUT_DEPTH));
                if (s_if.s_valid && w_s_ready) begin
                    mul_in_1 = s_if.s_a;
                    mul_in_2 = s_if.s_b;
                end
            end
            PH_B: begin
                w_phase_nxt = PH_A;
                mul_in_1    = r_hold_a;
                mul_in_2    = r_hold_b;
            end
            default: ;
        endcase
    end

    assign s_if.s_ready = w_s_ready;
    assign w_accept     = s_if.s_valid && w_s_ready;
    assign w_push       = r_inflight[MUL_LAT-1];
    assign w_pop        = s_if.m_valid && s_if.m_ready;
    assign s_if.m_valid = !w_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase    <= PH_A;
            r_hold_a   <= '0;
            r_hold_b   <= '0;
            r_inflight <= '0;
        end else begin
            r_phase    <= w_phase_nxt;
            r_inflight <= {r_inflight[MUL_LAT-2:0], w_accept};
            if (w_accept) begin
                r_hold_a <= s_if.s_a;
                r_hold_b <= s_if.s_b;
            end
        end
    end

    sync_fifo #(
        .WIDTH (PRODW),
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata (mul_prod),
        .i_pop   (w_pop),
        .o_rdata (s_if.m_prod),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_fifo_count)
    );

    a_credit_holds: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_push && w_full));
endmodule

// File: tb/tb_mult_8x8_issue.sv
// tb/tb_mult_8x8_issue.sv - bench for mult_8x8_issue driving a real mult_8x8
module tb_mult_8x8_issue;
    localparam int DEPTH = 4;

    typedef struct {
        logic [15:0] prod;
        int          rdy;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  mul_in_1;
    logic [7:0]  mul_in_2;
    logic [15:0] mul_prod;

    mult_8x8_issue_if bus();

    mult_8x8_issue #(.OUT_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_if     (bus),
        .mul_in_1 (mul_in_1),
        .mul_in_2 (mul_in_2),
        .mul_prod (mul_prod)
    );

    mult_8x8 u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .in_1  (mul_in_1),
        .in_2  (mul_in_2),
        .prod  (mul_prod)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_acc = 0;
    int n_pop = 0;
    exp_t q[$];
    int acc_log[$];
    int pop_log[$];
    logic [15:0] pop_val[$];
    bit prev_hs = 1'b0;
    logic [15:0] prev_ops = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // reference: outstanding ops = accepted minus popped; cycle parity gives the phase
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_s_ready", 32'(bus.s_ready), 32'd0);
            chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
            q.delete();
            cyc = 0;
            prev_hs = 1'b0;
        end else begin
            bit hs;
            hs = bus.s_valid && bus.s_ready;
            chk("s_ready", 32'(bus.s_ready), 32'((cyc % 2 == 0) && (q.size() < DEPTH)));
            chk("m_valid", 32'(bus.m_valid), 32'((q.size() > 0) && (q[0].rdy <= cyc)));
            if (cyc % 2 == 0) begin
                chk("mul_in_pha", {mul_in_1, mul_in_2}, hs ? {bus.s_a, bus.s_b} : 16'h0);
            end else if (prev_hs) begin
                chk("mul_in_phb", {mul_in_1, mul_in_2}, prev_ops);
            end
            if (bus.m_valid && bus.m_ready && q.size() > 0) begin
                chk("m_prod", 32'(bus.m_prod), 32'(q[0].prod));
                pop_log.push_back(cyc);
                pop_val.push_back(bus.m_prod);
                void'(q.pop_front());
                n_pop++;
            end
            if (hs) begin
                q.push_back('{prod: 16'(int'(bus.s_a) * int'(bus.s_b)), rdy: cyc + 3});
                acc_log.push_back(cyc);
                n_acc++;
            end
            prev_hs  = hs;
            prev_ops = {bus.s_a, bus.s_b};
            cyc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input bit keep);
        bit ok;
        ok = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_a = a;
        bus.s_b = b;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            ok = bus.s_ready;
            tick();
        end
        chk("send_accept", 32'(ok), 32'd1);
        if (!keep) bus.s_valid = 1'b0;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic        mv [8];
        logic [15:0] pr [8];
        int a0;
        int p0;
        int target;

        bus.s_valid = 1'b0;
        bus.s_a = '0;
        bus.s_b = '0;
        bus.m_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;

        // 1: single op in the first phase-A cycle
        bus.s_valid = 1'b1;
        bus.s_a = 8'h0F;
        bus.s_b = 8'h11;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            mv[i] = bus.m_valid;
            pr[i] = bus.m_prod;
            tick();
            bus.s_valid = 1'b0;
        end
        chk("t1_mv_c2", 32'(mv[2]), 32'd0);
        chk("t1_mv_c3", 32'(mv[3]), 32'd1);
        chk("t1_prod", 32'(pr[3]), 32'h00FF);
        chk("t1_mv_c4", 32'(mv[4]), 32'd0);

        // 2: back-to-back issue
        acc_log.delete();
        pop_log.delete();
        pop_val.delete();
        send(8'hFF, 8'hFF, 1'b1);
        send(8'h00, 8'h37, 1'b1);
        send(8'h80, 8'h02, 1'b0);
        repeat (8) tick();
        chk("t2_n_acc", 32'(acc_log.size()), 32'd3);
        chk("t2_n_pop", 32'(pop_log.size()), 32'd3);
        if (acc_log.size() == 3 && pop_log.size() == 3) begin
            chk("t2_acc_gap0", 32'(acc_log[1] - acc_log[0]), 32'd2);
            chk("t2_acc_gap1", 32'(acc_log[2] - acc_log[1]), 32'd2);
            chk("t2_pop_gap0", 32'(pop_log[1] - pop_log[0]), 32'd2);
            chk("t2_pop_gap1", 32'(pop_log[2] - pop_log[1]), 32'd2);
            chk("t2_res0", 32'(pop_val[0]), 32'hFE01);
            chk("t2_res1", 32'(pop_val[1]), 32'h0000);
            chk("t2_res2", 32'(pop_val[2]), 32'h0100);
        end

        // 3: back-pressure fills exactly OUT_DEPTH credits
        bus.m_ready = 1'b0;
        a0 = n_acc;
        p0 = n_pop;
        for (int i = 0; i < 20; i++) begin
            bus.s_valid = 1'b1;
            bus.s_a = 8'($urandom);
            bus.s_b = 8'($urandom);
            tick();
        end
        chk("t3_accepted", 32'(n_acc - a0), 32'd4);
        @(negedge clk);
        chk("t3_stalled", 32'(bus.s_ready), 32'd0);
        tick();
        bus.m_ready = 1'b1;
        for (int i = 0; i < 8 && (n_acc - a0) < 5; i++) tick();
        chk("t3_resume", 32'(n_acc - a0), 32'd5);
        bus.s_valid = 1'b0;
        repeat (10) tick();
        chk("t3_pops", 32'(n_pop - p0), 32'd5);
        @(negedge clk);
        chk("t3_empty", 32'(bus.m_valid), 32'd0);
        tick();

        // 4: request raised in a phase-B cycle
        if (cyc % 2 == 0) tick();
        a0 = n_acc;
        bus.s_valid = 1'b1;
        bus.s_a = 8'hA5;
        bus.s_b = 8'h3C;
        @(negedge clk);
        chk("t4_phb_ready", 32'(bus.s_ready), 32'd0);
        tick();
        @(negedge clk);
        chk("t4_pha_ready", 32'(bus.s_ready), 32'd1);
        tick();
        bus.s_valid = 1'b0;
        repeat (5) tick();
        chk("t4_acc", 32'(n_acc - a0), 32'd1);

        // 5: reset one cycle after an accept discards the op
        p0 = n_pop;
        send(8'h77, 8'h99, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t5_no_mvalid", 32'(bus.m_valid), 32'd0);
            tick();
        end
        chk("t5_no_pop", 32'(n_pop - p0), 32'd0);
        pop_val.delete();
        send(8'h12, 8'h34, 1'b0);
        for (int i = 0; i < 10 && pop_val.size() == 0; i++) tick();
        chk("t5_n_res", 32'(pop_val.size()), 32'd1);
        if (pop_val.size() > 0) chk("t5_res", 32'(pop_val[0]), 32'h03A8);

        // 6: random traffic against the scoreboard
        a0 = n_acc;
        target = n_acc + 10000;
        for (int c = 0; c < 60000 && n_acc < target; c++) begin
            bus.s_valid = ($urandom_range(7) != 0);
            bus.s_a = 8'($urandom);
            bus.s_b = 8'($urandom);
            bus.m_ready = ($urandom_range(7) != 0);
            tick();
        end
        chk("t6_ops", 32'(n_acc - a0), 32'd10000);
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b1;
        repeat (12) tick();
        chk("t6_drained", 32'(q.size()), 32'd0);
        @(negedge clk);
        chk("t6_m_valid", 32'(bus.m_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
